// File: rtl/bch_542_pkg.sv
// bch_542_pkg: shared constants, FSM state type and GF(2^10) helpers for the (542,512) BCH code.
// Provides MSG_W/PAR_W/CW_W/M, PRIM_POLY, GEN_POLY, G_LOW and lfsr_step_n(rem, data, n).
package bch_542_pkg;
    localparam int MSG_W = 512;
    localparam int PAR_W = 30;
    localparam int CW_W  = 542;
    localparam int M     = 10;
    localparam logic [M:0] PRIM_POLY = 11'h409;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_OUT} enc_state_e;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? PRIM_POLY[M-1:0] : '0);
            r = r ^ (b[i] ? a : '0);
        end
        return r;
    endfunction

    // Product of (x + beta^(2^k)) over the 10 conjugates; coefficients collapse to GF(2).
    function automatic logic [M:0] min_poly(input logic [M-1:0] beta);
        logic [M:0][M-1:0] p;
        logic [M-1:0]      b;
        logic [M:0]        m;
        p    = '0;
        p[0] = M'(1);
        b    = beta;
        for (int c = 0; c < M; c++) begin
            for (int j = M; j >= 1; j--)
                p[j] = p[j-1] ^ gf_mul(b, p[j]);
            p[0] = gf_mul(b, p[0]);
            b    = gf_mul(b, b);
        end
        for (int j = 0; j <= M; j++)
            m[j] = p[j][0];
        return m;
    endfunction

    function automatic logic [PAR_W:0] poly_mul(input logic [PAR_W:0] a, input logic [M:0] b);
        logic [PAR_W:0] r;
        r = '0;
        for (int i = 0; i <= M; i++)
            r = r ^ (b[i] ? (a << i) : '0);
        return r;
    endfunction

    // g(x) = m1(x) * m3(x) * m5(x); the three cyclotomic cosets are distinct, so lcm = product.
    localparam logic [PAR_W:0] GEN_POLY =
        poly_mul(poly_mul((PAR_W+1)'(min_poly(10'h002)), min_poly(10'h008)), min_poly(10'h020));
    localparam logic [PAR_W-1:0] G_LOW = GEN_POLY[PAR_W-1:0];

    // Folds data[n-1:0] (MSB first) into rem; n is constant at every call site so this unrolls.
    function automatic logic [PAR_W-1:0] lfsr_step_n(input logic [PAR_W-1:0] rem,
                                                     input logic [255:0] data, input int n);
        logic [PAR_W-1:0] r;
        logic             fb;
        r = rem;
        for (int i = 255; i >= 0; i--) begin
            if (i < n) begin
                fb = r[PAR_W-1] ^ data[i];
                r  = {r[PAR_W-2:0], 1'b0} ^ (fb ? G_LOW : '0);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/bch_par_lfsr.sv
// bch_par_lfsr: combinational parallel LFSR, rem_o = (rem_i*x^BEAT_W + data_i*x^30) mod g(x).
// Ports: rem_i (current remainder), data_i (beat, MSB = highest power), rem_o (next remainder).
module bch_par_lfsr
    import bch_542_pkg::*;
#(
    parameter int BEAT_W = 128
) (
    input  logic [PAR_W-1:0]  rem_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic [PAR_W-1:0]  rem_o
);
    assign rem_o = lfsr_step_n(rem_i, 256'(data_i), BEAT_W);
endmodule

// File: rtl/bch_encoder_seq.sv
// bch_encoder_seq: multi-cycle systematic (542,512) BCH encoder, 128-bit beats in, one codeword out.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data (beats, MSB first),
//        out_valid/out_ready/out_codeword ({message, parity}), busy (state != IDLE).
// Option: BCH_ENC_ERR_INJ_EN adds err_inj_mask, sampled on the final beat and XORed into the codeword.
module bch_encoder_seq
    import bch_542_pkg::*;
#(
    parameter int BEAT_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_codeword,
`ifdef BCH_ENC_ERR_INJ_EN
    input  logic [CW_W-1:0]   err_inj_mask,
`endif
    output logic              busy
);
    localparam int NB    = MSG_W / BEAT_W;
    localparam int CNT_W = $clog2(NB);

    enc_state_e         state_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [PAR_W-1:0]   rem_q, rem_d, rem_src;
    logic [MSG_W-1:0]   msg_buf_q, msg_d;
    logic [CW_W-1:0]    cw_q, cw_d, inj;
    logic               out_valid_q, last;

`ifdef BCH_ENC_ERR_INJ_EN
    assign inj = err_inj_mask;
`else
    assign inj = '0;
`endif

    // A new message starts from a zero remainder; rem_q still holds the previous parity in IDLE.
    assign rem_src = (state_q == ST_IDLE) ? '0 : rem_q;

    bch_par_lfsr #(.BEAT_W(BEAT_W)) u_lfsr (
        .rem_i  (rem_src),
        .data_i (in_data),
        .rem_o  (rem_d)
    );

    assign msg_d = {msg_buf_q[MSG_W-BEAT_W-1:0], in_data};
    assign cw_d  = {msg_d, rem_d} ^ inj;
    assign last  = (beat_cnt_q == CNT_W'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            rem_q       <= '0;
            msg_buf_q   <= '0;
            cw_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    rem_q      <= rem_d;
                    msg_buf_q  <= msg_d;
                    beat_cnt_q <= CNT_W'(1);
                    state_q    <= ST_ACCUM;
                end
                ST_ACCUM: if (in_valid) begin
                    rem_q      <= rem_d;
                    msg_buf_q  <= msg_d;
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    if (last) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        cw_q        <= cw_d;
                    end
                end
                ST_OUT: if (out_ready) begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q != ST_OUT);
    assign busy         = (state_q != ST_IDLE);
    assign out_valid    = out_valid_q;
    assign out_codeword = cw_q;
endmodule

// File: tb/tb_bch_encoder_seq.sv
// tb_bch_encoder_seq: scoreboard bench for bch_encoder_seq with directed messages, gaps, stalls and reset.
module tb_bch_encoder_seq;
    import bch_542_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [127:0]      in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CW_W-1:0]   out_codeword;
    logic              busy;
`ifdef BCH_ENC_ERR_INJ_EN
    logic [CW_W-1:0]   err_mask = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit stall_en = 1'b0;
    bit syn_chk  = 1'b1;
    logic [CW_W-1:0] exp_q[$];

    bch_encoder_seq #(.BEAT_W(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
`ifdef BCH_ENC_ERR_INJ_EN
        .err_inj_mask (err_mask),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic ok, input logic [CW_W-1:0] act, input logic [CW_W-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent GF(2^10) arithmetic, alpha^10 = alpha^3 + 1.
    function automatic logic [9:0] tb_gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] r = '0;
        for (int i = 9; i >= 0; i--) begin
            r = {r[8:0], 1'b0} ^ (r[9] ? 10'h009 : 10'h000);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [9:0] syndrome(input logic [CW_W-1:0] c, input logic [9:0] beta);
        logic [9:0] s = '0;
        for (int i = CW_W - 1; i >= 0; i--)
            s = tb_gf_mul(s, beta) ^ {9'b0, c[i]};
        return s;
    endfunction

    // Reference codeword by long division of m(x)*x^30 by g(x).
    function automatic logic [CW_W-1:0] ref_cw(input logic [511:0] m);
        logic [CW_W-1:0] c = {m, 30'b0};
        for (int i = CW_W - 1; i >= 30; i--)
            if (c[i]) c = c ^ (CW_W'(GEN_POLY) << (i - 30));
        return {m, c[29:0]};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    logic [CW_W-1:0] prev_cw;
    bit              prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_low_in_out", !in_ready, CW_W'(in_ready), '0);
            if (prev_stall) chk("stall_stable", out_codeword == prev_cw, out_codeword, prev_cw);
            if (out_ready) begin
                prev_stall = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_codeword", 1'b0, out_codeword, '0);
                end else begin
                    logic [CW_W-1:0] e;
                    e = exp_q.pop_front();
                    chk("codeword", out_codeword == e, out_codeword, e);
                    if (syn_chk) begin
                        chk("syn_a1", syndrome(out_codeword, 10'h002) == 0, CW_W'(syndrome(out_codeword, 10'h002)), '0);
                        chk("syn_a3", syndrome(out_codeword, 10'h008) == 0, CW_W'(syndrome(out_codeword, 10'h008)), '0);
                        chk("syn_a5", syndrome(out_codeword, 10'h020) == 0, CW_W'(syndrome(out_codeword, 10'h020)), '0);
                    end
                end
            end else begin
                prev_stall = 1'b1;
                prev_cw    = out_codeword;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_beat(input logic [127:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++t > 100) begin
                chk("beat_timeout", 1'b0, CW_W'(t), '0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_msg(input logic [511:0] msg, input logic [CW_W-1:0] exp, input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_beat(msg[511 - 128*b -: 128]);
            if (b == 3) exp_q.push_back(exp);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", 1'b0, CW_W'(exp_q.size()), '0);
    endtask

    function automatic logic [511:0] rand_msg();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    initial begin
        logic [511:0] m;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready == 1'b1, CW_W'(in_ready), CW_W'(1));
        chk("rst_out_valid", out_valid == 1'b0, CW_W'(out_valid), '0);
        chk("rst_codeword", out_codeword == '0, out_codeword, '0);
        chk("rst_busy", busy == 1'b0, CW_W'(busy), '0);
        rst_n = 1'b1;

        send_msg('0, '0, 1'b0);
        chk("zero_latency_valid", out_valid == 1'b1, CW_W'(out_valid), CW_W'(1));
        @(posedge clk);
        #1;
        chk("zero_busy_drop", busy == 1'b0, CW_W'(busy), '0);
        chk("zero_valid_drop", out_valid == 1'b0, CW_W'(out_valid), '0);

        send_msg(512'h1, {512'h1, G_LOW}, 1'b0);
        send_msg({512{1'b1}}, ref_cw({512{1'b1}}), 1'b0);
        send_msg({16{32'hDEADBEEF}}, ref_cw({16{32'hDEADBEEF}}), 1'b1);
        send_msg({4{128'h0123456789abcdef_fedcba9876543210}},
                 ref_cw({4{128'h0123456789abcdef_fedcba9876543210}}), 1'b1);
        send_msg({1'b1, 511'b0}, ref_cw({1'b1, 511'b0}), 1'b0);
        drain();

        stall_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m = rand_msg();
            send_msg(m, ref_cw(m), 1'b1);
        end
        drain();
        stall_en = 1'b0;
        drain();

        send_beat(128'hFFFF_0000_FFFF_0000_1234_5678_9abc_def0);
        send_beat(128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0);
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", busy == 1'b0, CW_W'(busy), '0);
        chk("midrst_in_ready", in_ready == 1'b1, CW_W'(in_ready), CW_W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_valid", out_valid == 1'b0, CW_W'(out_valid), '0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_valid", out_valid == 1'b0, CW_W'(out_valid), '0);
        m = {128'h1, 128'h2, 128'h3, 128'h4};
        send_msg(m, ref_cw(m), 1'b0);
        drain();

`ifdef BCH_ENC_ERR_INJ_EN
        syn_chk  = 1'b0;
        err_mask = CW_W'(1);
        m = rand_msg();
        send_msg(m, ref_cw(m) ^ CW_W'(1), 1'b0);
        err_mask = '0;
        drain();
        syn_chk  = 1'b1;
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/bch_encoder_seq.md
Name: bch_encoder_seq

Overview:
Multi-cycle systematic encoder for the (542,512) triple-error-correcting BCH code over GF(2^10). It sits directly upstream of the combinational BCH decoder/corrector. It accepts a 512-bit message as 128-bit beats over a valid/ready handshake and computes the 30-bit parity with a parallel LFSR. It emits one 542-bit codeword in the decoder's native layout: message in [541:30], parity in [29:0].

Parameters:
BEAT_W, 128, message bits accepted per input beat; must divide MSG_W (legal: 32, 64, 128, 256).
MSG_W, 512, message width; fixed by the code, not overridable in practice.
PAR_W, 30, parity width (3 x m, m=10).

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  message beat valid.
in_ready  output  1  encoder can accept a beat.
in_data  input  BEAT_W  message beat; beat 0 = message[511:384] (MSB first).
out_valid  output  1  codeword valid.
out_ready  input  1  consumer accepts codeword.
out_codeword  output  542  {message[511:0], parity[29:0]}.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, beat_cnt=0, rem=0, msg_buf=0; in_ready=1, out_valid=0, out_codeword=0, busy=0.
- States:
  - IDLE: a beat transfer (in_valid & in_ready) loads rem and stores the beat; beat_cnt=1; go to ACCUM.
  - ACCUM: each transfer folds one beat and increments beat_cnt. On the transfer with beat_cnt == MSG_W/BEAT_W-1, go to OUT.
  - OUT: out_valid=1 and in_ready=0. On out_ready, return to IDLE.
- in_ready = (state != OUT). No combinational path from out_ready to in_ready.
- LFSR update per beat: rem' = (rem*x^BEAT_W + d(x)*x^30) mod g(x), where d is the beat with its MSB as the highest power.
  - Implemented as a function iterating BEAT_W serial steps, with the constant unrolled to XOR trees.
  - Serial step: fb = rem[29] ^ bit; rem = {rem[28:0],1'b0} ^ (fb ? G_LOW : 0).
- Parity = rem after the final beat. No extra cycle: the OUT state presents the registered result.
- msg_buf shifts left by BEAT_W per beat, so after the last beat msg_buf[511:0] = message.
- out_codeword and out_valid are registered and held stable while out_valid & ~out_ready (AXI-style stability).
- Latency: the codeword is valid the cycle after the last beat handshake. Throughput is 1 codeword per MSG_W/BEAT_W+1 cycles minimum.
- in_valid gaps during ACCUM: state holds, rem and beat_cnt unchanged.
- Reset mid-operation: asynchronously returns every register to its reset value. A partial message is discarded and no codeword is emitted.
- in_data while ~in_valid is ignored. X on in_data when ~in_valid must not propagate into state.

Optional Feature:
BCH_ENC_ERR_INJ_EN:
- Defined: adds input err_inj_mask [541:0], sampled on the final beat handshake and XORed into out_codeword. Used for decoder verification (1–3 bit flips must correct; 4 must detect or miscorrect per code properties).
- Undefined: the port does not exist and the output is the pure codeword.

Decomposition:
- Package bch_542_pkg holds:
  - MSG_W, PAR_W, CW_W=542, M=10.
  - PRIM_POLY (x^10+x^3+1).
  - GEN_POLY[30:0] = lcm of the minimal polynomials of alpha, alpha^3, alpha^5, with G_LOW = GEN_POLY[29:0].
  - function lfsr_step_n(rem, data).
- Natural sub-module: bch_par_lfsr (combinational rem/beat -> rem' network), instantiated once.
- The package is shared with the decoder's syndrome constants.

Test Plan:
- All-zero message, 4 back-to-back beats, out_ready=1: out_valid 1 cycle after beat 4; codeword = 542'b0; busy drops next cycle.
- Message with only bit 0 set (beat 3 = 128'h1): parity = x^30 mod g(x), which must equal G_LOW; message field = 512'h1.
- Random messages x1000, with random in_valid gaps and out_ready stalls of 0–5 cycles: parity matches the bit-serial reference model. out_codeword stays stable during stalls, and in_ready=0 throughout OUT.
- Loopback with the decoder (bypass=0), flipping 0–3 random bits of the output: decoder detection set iff errors >0, and the corrected message equals the original for all cases.
- Assert rst_n low after beat 2: out_valid stays 0. A fresh 4-beat message afterwards encodes correctly, with no contamination from the old rem.
- With BCH_ENC_ERR_INJ_EN, mask=542'h1: out_codeword differs from the golden codeword only in bit 0.
